// File: rtl/note_chart_sequencer_if.sv
// rtl/note_chart_sequencer_if.sv - chart ROM address/data bus between sequencer and registered ROM
interface note_chart_sequencer_if #(
    parameter int CHART_AW = 8
);
    logic [CHART_AW-1:0] chart_addr;
    logic [31:0]         chart_data;

    modport master (output chart_addr, input chart_data);
    modport slave  (input chart_addr, output chart_data);
endinterface

// File: rtl/note_chart_sequencer.sv
// rtl/note_chart_sequencer.sv - note chart fetch, slot allocation and scroll; NOTE_CHART_LOOP_EN restarts the chart at its end marker
module note_chart_sequencer #(
    parameter int NUM_SLOTS = 26,
    parameter int CHART_AW  = 8,
    parameter int SPEED     = 1,
    parameter int SCREEN_H  = 480,
    parameter int NOTE_W    = 20
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   run,
    note_chart_sequencer_if.master chart,
    output logic [6:0]             numRectangles,
    output logic [NUM_SLOTS*43-1:0] rectangles,
    output logic [6:0]             active_count,
    output logic [15:0]            frame_count,
    output logic                   stall,
    output logic                   done
);
    typedef enum logic [1:0] {S_ADDR, S_EVAL, S_END} state_t;

    localparam logic signed [12:0] SPEED_Y  = 13'(SPEED);
    localparam logic signed [12:0] LIMIT_Y  = 13'(SCREEN_H);

    state_t                state, next_state;
    logic [CHART_AW-1:0]   ptr;
    logic                  valid [NUM_SLOTS];
    logic [9:0]            slot_x [NUM_SLOTS];
    logic signed [12:0]    slot_y [NUM_SLOTS];
    logic [9:0]            slot_h [NUM_SLOTS];

    logic [15:0]           entry_frame;
    logic [3:0]            entry_lane;
    logic [9:0]            entry_h;
    logic                  unused_reserved;
    logic                  free_found;
    logic [6:0]            free_idx;
    logic                  ptr_inc, spawn, blocked, loop_restart;

    assign entry_frame     = chart.chart_data[31:16];
    assign entry_lane      = chart.chart_data[15:12];
    assign entry_h         = chart.chart_data[9:0];
    assign unused_reserved = ^chart.chart_data[11:10];
    assign chart.chart_addr = ptr;
    assign numRectangles   = 7'(NUM_SLOTS);

    function automatic logic [9:0] lane_to_x(input logic [3:0] lane);
        case (lane)
            4'd0:    lane_to_x = 10'd0;
            4'd1:    lane_to_x = 10'd54;
            4'd2:    lane_to_x = 10'd107;
            4'd3:    lane_to_x = 10'd160;
            4'd4:    lane_to_x = 10'd214;
            4'd5:    lane_to_x = 10'd267;
            4'd6:    lane_to_x = 10'd320;
            4'd7:    lane_to_x = 10'd374;
            4'd8:    lane_to_x = 10'd427;
            4'd9:    lane_to_x = 10'd480;
            4'd10:   lane_to_x = 10'd534;
            4'd11:   lane_to_x = 10'd587;
            default: lane_to_x = 10'd0;
        endcase
    endfunction

    // lowest-index free slot, taken from registered valid bits only
    always_comb begin
        free_found = 1'b0;
        free_idx   = 7'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = 7'(i);
            end
        end
    end

    // fetch FSM next-state and per-cycle actions
    always_comb begin
        next_state   = state;
        ptr_inc      = 1'b0;
        spawn        = 1'b0;
        blocked      = 1'b0;
        loop_restart = 1'b0;
        case (state)
            S_ADDR: next_state = S_EVAL;
            S_EVAL: begin
                if (entry_lane == 4'd15) begin
`ifdef NOTE_CHART_LOOP_EN
                    loop_restart = 1'b1;
                    next_state   = S_ADDR;
`else
                    next_state   = S_END;
`endif
                end else if (entry_frame > frame_count) begin
                    next_state = S_EVAL;
                end else if (entry_lane >= 4'd12) begin
                    ptr_inc    = 1'b1;
                    next_state = S_ADDR;
                end else if (free_found) begin
                    spawn      = 1'b1;
                    ptr_inc    = 1'b1;
                    next_state = S_ADDR;
                end else begin
                    blocked    = 1'b1;
                end
            end
            S_END:   next_state = S_END;
            default: next_state = S_ADDR;
        endcase
    end

    // FSM, chart pointer, frame counter and status flags
    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state       <= S_ADDR;
            ptr         <= '0;
            frame_count <= 16'd0;
            stall       <= 1'b0;
            done        <= 1'b0;
        end else if (run) begin
            state <= next_state;
            if (loop_restart)
                ptr <= '0;
            else if (ptr_inc)
                ptr <= ptr + 1'b1;
            if (loop_restart)
                frame_count <= 16'd0;
            else if (frame_count != 16'hFFFF)
                frame_count <= frame_count + 16'd1;
            stall <= blocked;
            done  <= (state == S_END) && (active_count == 7'd0);
        end
    end

    // slot scroll/retire and spawn; a freshly spawned slot is not scrolled this cycle
    always_ff @(posedge frame_clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!Reset) begin
                valid[i]  <= 1'b0;
                slot_x[i] <= 10'd0;
                slot_y[i] <= 13'sd0;
                slot_h[i] <= 10'd0;
            end else if (run) begin
                if (valid[i]) begin
                    if (slot_y[i] + SPEED_Y >= LIMIT_Y)
                        valid[i] <= 1'b0;
                    slot_y[i] <= slot_y[i] + SPEED_Y;
                end else if (spawn && free_idx == 7'(i)) begin
                    valid[i]  <= 1'b1;
                    slot_x[i] <= lane_to_x(entry_lane);
                    slot_y[i] <= 13'sd0 - $signed({3'b000, entry_h});
                    slot_h[i] <= entry_h;
                end
            end
        end
    end

    // live-slot count and rectangle bus packing (slot 0 in the MSBs, dead slots zero)
    always_comb begin
        active_count = 7'd0;
        rectangles   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active_count = active_count + 7'(valid[i]);
            if (valid[i])
                rectangles[(NUM_SLOTS - 1 - i) * 43 +: 43] =
                    {slot_x[i], slot_y[i], 10'(NOTE_W), slot_h[i]};
        end
    end
endmodule

// File: doc/note_chart_sequencer.md
# note_chart_sequencer

Parametrised successor to the fixed per-song rectangle charts. Reads a note chart (spawn frame, lane, length) from an external registered ROM, allocates notes into a pool of NUM_SLOTS scrolling slots, advances each live slot by SPEED pixels per frame, and retires slots that pass the bottom of the screen. Sits between the chart ROM and the rectangle renderer and drives the same packed rectangle bus and count the renderer already consumes.

## Interface
- NUM_SLOTS, 26: number of concurrent note slots (1..127).
- CHART_AW, 8: chart ROM address width.
- SPEED, 1: pixels added to Y per run frame (1..15).
- SCREEN_H, 480: slot retires when Y ≥ SCREEN_H.
- NOTE_W, 20: width field for every live note.
- frame_clk  in  1  frame clock; sole clock.
- Reset  in  1  synchronous, active-low reset.
- run  in  1  1 = advance frame counter, scroll and fetch; 0 = freeze all state.
- chart_addr  out  CHART_AW  ROM address; data returns on chart_data one cycle later.
- chart_data  in  32  entry: [31:16] spawn frame, [15:12] lane, [11:10] reserved, [9:0] height.
- numRectangles  out  7  constant NUM_SLOTS.
- rectangles  out  NUM_SLOTS*43  packed slots; slot 0 in MSBs; per slot {X[9:0], Y[12:0] signed, W[9:0], H[9:0]}.
- active_count  out  7  number of live slots.
- frame_count  out  16  run frames since reset/loop; saturates at 16'hFFFF.
- stall  out  1  entry is due but no slot is free.
- done  out  1  end marker reached and active_count == 0.

## Operation
- Lane → X: 0,54,107,160,214,267,320,374,427,480,534,587 (C..B). Lanes 12–14: entry skipped. Lane 15: end marker.
- Dead slots pack as all-zero (X=Y=W=H=0); live slots pack {lane X, Y, NOTE_W, height}.
- Fetch FSM: ADDR → EVAL → (ADDR | EVAL | END).
  - ADDR: chart_addr = ptr; next state EVAL.
  - EVAL (chart_data valid): lane 15 → END. spawn frame > frame_count → stay EVAL. Lanes 12–14 → ptr+1, ADDR. Otherwise, if a free slot exists: lowest-index free slot ← {valid, X, Y = −height, H}, ptr+1, ADDR; else stall=1, stay EVAL.
  - END: terminal; chart_addr holds.
- Late entries spawn at Y = −height; no catch-up offset.
- Scroll, each run cycle: live Y += SPEED (13-bit signed); if new Y ≥ SCREEN_H, slot cleared in same update.
- Free-slot search uses registered valid bits: a slot retiring this cycle is reusable next cycle; no same-cycle retire+spawn.
- active_count = popcount of registered valid bits.
- ptr increments modulo 2^CHART_AW; the chart must contain an end marker.

## Timing
- Reset (Reset=0 at edge): all slots dead, ptr=0, frame_count=0, state ADDR, chart_addr=0, stall=0, done=0, active_count=0, rectangles=0; numRectangles=NUM_SLOTS always.
- Reset overrides run and any in-progress fetch/spawn.
- run=0: no register changes (FSM, ptr, slots, frame_count, stall hold).
- Minimum two cycles per consumed entry; spawn visible on rectangles the edge after EVAL accepts.
- Spawn and scroll in one cycle: the new slot is written at Y = −height and is not scrolled that cycle.
- frame_count increments on every run cycle, including in END.
- stall is registered, asserted in cycles where EVAL is blocked on a full pool, cleared on the spawn.

## Configuration
- NOTE_CHART_LOOP_EN defined: EVAL on lane 15 sets ptr=0, frame_count=0, state ADDR; live slots keep scrolling; END unused; done stays 0.
- Not defined: lane 15 enters END; done rises once active_count == 0.

## Test plan
- Reset: hold Reset=0 two cycles with run=1 → rectangles=0, chart_addr=0, active_count=0, numRectangles=26, done=0.
- ROM {0,6,30}, then end marker; run=1 → two cycles after reset release, slot 0 = {320, −30, 20, 30}; Y reaches 479 after 509 further cycles, slot cleared on the next edge; done=1 one cycle later.
- ROM {100,2,30} → no spawn while frame_count < 100; slot 0 = {107, −30, 20, 30} on the edge after frame_count reaches 100.
- NUM_SLOTS=2, three entries {0,4,30}, SCREEN_H=40 → stall=1 until slot 0 retires; third note lands in slot 0 the cycle after retirement.
- Drop run to 0 for 50 cycles mid-scroll → Y, frame_count, chart_addr unchanged; resume continues from held values.
- Chart {0,13,30},{0,0,30}, end marker → lane 13 skipped, slot 0 X=0. With NOTE_CHART_LOOP_EN: at end marker, chart_addr returns to 0, frame_count to 0, and done stays 0.
